// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for the delayed-branch resolve controller:
// condition codes, FSM states, slot bundle and predictor helpers.
package branch_resolve_ctrl_pkg;

  typedef enum logic [2:0] {
    C_NV = 3'd0,
    C_AL = 3'd1,
    C_EQ = 3'd2,
    C_NE = 3'd3,
    C_LT = 3'd4,
    C_LE = 3'd5,
    C_GT = 3'd6,
    C_GE = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH1 = 2'd1,
    ST_FLUSH2 = 2'd2
  } state_e;

  typedef struct packed {
    logic        v0;
    logic [15:0] d0;
    cond_e       c0;
    logic [3:0]  i0;
    logic        t0;
    logic        v1;
    logic [15:0] d1;
    cond_e       c1;
    logic [3:0]  i1;
    logic        t1;
  } slot_t;

  localparam logic [1:0] CTR_RST = 2'b01;

  function automatic logic is_cond(input cond_e c);
    return (c != C_AL) && (c != C_NV);
  endfunction

  function automatic logic [1:0] sat_upd(
    input logic [1:0] c,
    input logic       up
  );
    if (up)
      return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Evaluates one condition code against the stage-3 N/V/Z flags.
module cond_eval
  import branch_resolve_ctrl_pkg::*;
(
  input  cond_e cond_i,
  input  logic  n_i,
  input  logic  v_i,
  input  logic  z_i,
  output logic  true_o
);

  logic lt;
  assign lt = n_i ^ v_i;

  always_comb begin
    true_o = 1'b0;
    unique case (cond_i)
      C_NV: true_o = 1'b0;
      C_AL: true_o = 1'b1;
      C_EQ: true_o = z_i;
      C_NE: true_o = ~z_i;
      C_LT: true_o = lt;
      C_LE: true_o = z_i | lt;
      C_GT: true_o = ~z_i & ~lt;
      C_GE: true_o = ~lt;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Two-slot delayed-branch resolver with flush FSM.
// Define BRANCH_PRED_EN to add the 16-entry 2-bit predictor.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_next_in,
  input  logic        N,
  input  logic        V,
  input  logic        Z,
  input  logic        p0_push,
  input  logic        p1_push,
  input  logic [15:0] p0_dest,
  input  logic [15:0] p1_dest,
  input  logic [2:0]  p0_cond,
  input  logic [2:0]  p1_cond,
  input  logic [3:0]  p0_pidx,
  input  logic [3:0]  p1_pidx,
  input  logic        p0_took,
  input  logic        p1_took,
  input  logic [3:0]  pred_idx,
  output logic        redirect_valid,
  output logic [8:0]  redirect_pc,
  output logic        redirect_ir0_inv,
  output logic        flush,
  output logic        prediction
);

  slot_t  iss_q, iss_d;
  slot_t  res_q, res_d;
  slot_t  push_s;
  state_e state_q, state_d;

  logic ct0, ct1;
  logic adv, fire0, fire1, fire;

  cond_eval u_ce0 (
    .cond_i (res_q.c0),
    .n_i    (N),
    .v_i    (V),
    .z_i    (Z),
    .true_o (ct0)
  );

  cond_eval u_ce1 (
    .cond_i (res_q.c1),
    .n_i    (N),
    .v_i    (V),
    .z_i    (Z),
    .true_o (ct1)
  );

  assign adv   = fetch_next_in & (state_q == ST_RUN) & ~rst;
  assign fire0 = adv & res_q.v0 & ct0;
  assign fire1 = adv & ~fire0 & res_q.v1 & ct1;
  assign fire  = fire0 | fire1;

  always_comb begin
    push_s    = '0;
    push_s.v0 = p0_push;
    push_s.d0 = p0_dest;
    push_s.c0 = cond_e'(p0_cond);
    push_s.i0 = p0_pidx;
    push_s.t0 = p0_took;
    push_s.v1 = p1_push;
    push_s.d1 = p1_dest;
    push_s.c1 = cond_e'(p1_cond);
    push_s.i1 = p1_pidx;
    push_s.t1 = p1_took;
  end

  // A redirect also squashes the entry being resolved and any push.
  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    res_d   = res_q;
    if (fetch_next_in) begin
      unique case (state_q)
        ST_RUN: begin
          if (fire) begin
            state_d = ST_FLUSH1;
            iss_d   = '0;
            res_d   = '0;
          end else begin
            res_d = iss_q;
            iss_d = push_s;
          end
        end
        ST_FLUSH1: state_d = ST_FLUSH2;
        ST_FLUSH2: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      iss_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    redirect_pc      = '0;
    redirect_ir0_inv = 1'b0;
    unique case (1'b1)
      fire0: begin
        redirect_pc      = {res_q.d0[8:1], 1'b0};
        redirect_ir0_inv = res_q.d0[0];
      end
      fire1: begin
        redirect_pc      = {res_q.d1[8:1], 1'b0};
        redirect_ir0_inv = res_q.d1[0];
      end
      default: ;
    endcase
  end

  assign redirect_valid = fire;
  assign flush = ~rst & (fire | (state_q != ST_RUN));

`ifdef BRANCH_PRED_EN
  logic [1:0] ctr_q [16];
  logic [1:0] ctr_d [16];

  // p0 is applied first so a same-index pair updates in age order.
  always_comb begin
    ctr_d = ctr_q;
    if (adv) begin
      if (res_q.v0 && is_cond(res_q.c0))
        ctr_d[res_q.i0] = sat_upd(ctr_d[res_q.i0], res_q.t0 ^ ct0);
      if (res_q.v1 && !fire0 && is_cond(res_q.c1))
        ctr_d[res_q.i1] = sat_upd(ctr_d[res_q.i1], res_q.t1 ^ ct1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++)
        ctr_q[k] <= CTR_RST;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign prediction = ctr_q[pred_idx][1];

  logic unused_ok;
  assign unused_ok = ^{res_q.d0[15:9], res_q.d1[15:9]};
`else
  assign prediction = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{pred_idx, res_q.i0, res_q.i1,
                       res_q.t0, res_q.t1,
                       res_q.d0[15:9], res_q.d1[15:9]};
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized self-checking bench for branch_resolve_ctrl with an
// entry-queue reference model and directed literal scenarios.
module tb_branch_resolve_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_next_in, N, V, Z;
  logic        p0_push, p1_push, p0_took, p1_took;
  logic [15:0] p0_dest, p1_dest;
  logic [2:0]  p0_cond, p1_cond;
  logic [3:0]  p0_pidx, p1_pidx, pred_idx;
  logic        redirect_valid, redirect_ir0_inv, flush, prediction;
  logic [8:0]  redirect_pc;

  branch_resolve_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_next_in    (fetch_next_in),
    .N                (N),
    .V                (V),
    .Z                (Z),
    .p0_push          (p0_push),
    .p1_push          (p1_push),
    .p0_dest          (p0_dest),
    .p1_dest          (p1_dest),
    .p0_cond          (p0_cond),
    .p1_cond          (p1_cond),
    .p0_pidx          (p0_pidx),
    .p1_pidx          (p1_pidx),
    .p0_took          (p0_took),
    .p1_took          (p1_took),
    .pred_idx         (pred_idx),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ir0_inv (redirect_ir0_inv),
    .flush            (flush),
    .prediction       (prediction)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] d;
    logic [2:0]  c;
    logic [3:0]  i;
    logic        t;
    int          stage;
  } ent_t;

  ent_t q[$];
  ent_t nq[$];
  ent_t e;
  int   flush_left = 0;
  int   ctr[16];
  bit   model_ok = 0;

  function automatic bit ctrue(input logic [2:0] c, input logic n,
                               input logic v, input logic z);
    bit lt;
    lt = n ^ v;
    case (c)
      3'd0: return 0;
      3'd1: return 1;
      3'd2: return z;
      3'd3: return !z;
      3'd4: return lt;
      3'd5: return z || lt;
      3'd6: return !z && !lt;
      default: return !lt;
    endcase
  endfunction

  logic       e_rv, e_inv, e_fl, e_pred;
  logic [8:0] e_pc;
  int         hit;
  bit         act;

  always @(negedge clk) begin
    e_rv = 0; e_pc = '0; e_inv = 0; e_fl = 0; hit = -1;
    if (!rst) begin
      if (flush_left > 0) e_fl = 1;
      else if (fetch_next_in) begin
        foreach (q[k])
          if (hit < 0 && q[k].stage == 1 && ctrue(q[k].c, N, V, Z))
            hit = k;
        if (hit >= 0) begin
          e_rv  = 1;
          e_fl  = 1;
          e_pc  = {q[hit].d[8:1], 1'b0};
          e_inv = q[hit].d[0];
        end
      end
    end
`ifdef BRANCH_PRED_EN
    e_pred = (ctr[pred_idx] >= 2);
`else
    e_pred = 0;
`endif
    if (model_ok) begin
      chk("m_redirect_valid", 32'(redirect_valid), 32'(e_rv));
      chk("m_redirect_pc", 32'(redirect_pc), 32'(e_pc));
      chk("m_ir0_inv", 32'(redirect_ir0_inv), 32'(e_inv));
      chk("m_flush", 32'(flush), 32'(e_fl));
      chk("m_prediction", 32'(prediction), 32'(e_pred));
    end
    if (rst) begin
      q.delete();
      flush_left = 0;
      for (int k = 0; k < 16; k++) ctr[k] = 1;
      model_ok = 1;
    end else if (fetch_next_in) begin
      if (flush_left > 0) flush_left--;
      else begin
        foreach (q[k]) begin
          if (q[k].stage == 1 && (hit < 0 || k <= hit) && q[k].c >= 2) begin
            act = q[k].t ^ ctrue(q[k].c, N, V, Z);
            if (act) ctr[q[k].i] = (ctr[q[k].i] < 3) ? ctr[q[k].i] + 1 : 3;
            else     ctr[q[k].i] = (ctr[q[k].i] > 0) ? ctr[q[k].i] - 1 : 0;
          end
        end
        if (hit >= 0) begin
          q.delete();
          flush_left = 2;
        end else begin
          nq.delete();
          foreach (q[k])
            if (q[k].stage == 0) begin
              e = q[k];
              e.stage = 1;
              nq.push_back(e);
            end
          if (p0_push) nq.push_back('{p0_dest, p0_cond, p0_pidx, p0_took, 0});
          if (p1_push) nq.push_back('{p1_dest, p1_cond, p1_pidx, p1_took, 0});
          q = nq;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_next_in = 1; N = 0; V = 0; Z = 0;
    p0_push = 0; p1_push = 0;
  endtask

  task automatic push(input int lane, input logic [15:0] d,
                      input logic [2:0] c, input logic [3:0] i,
                      input logic t);
    if (lane == 0) begin
      p0_push = 1; p0_dest = d; p0_cond = c; p0_pidx = i; p0_took = t;
    end else begin
      p1_push = 1; p1_dest = d; p1_cond = c; p1_pidx = i; p1_took = t;
    end
  endtask

  initial begin
    rst = 1; pred_idx = 0;
    p0_dest = 0; p1_dest = 0; p0_cond = 0; p1_cond = 0;
    p0_pidx = 0; p1_pidx = 0; p0_took = 0; p1_took = 0;
    idle();
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("rst_rv", 32'(redirect_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_pc", 32'(redirect_pc), 0);
    chk("rst_inv", 32'(redirect_ir0_inv), 0);
    chk("rst_pred", 32'(prediction), 0);

    // EQ taken, flush lasts three cycles
    tick(); push(0, 16'h0024, 3'd2, 4'd0, 1'b0);
    tick(); idle();
    tick(); Z = 1;
    @(negedge clk);
    chk("A_rv", 32'(redirect_valid), 1);
    chk("A_pc", 32'(redirect_pc), 32'h024);
    chk("A_inv", 32'(redirect_ir0_inv), 0);
    chk("A_fl0", 32'(flush), 1);
    tick(); Z = 0;
    @(negedge clk); chk("A_fl1", 32'(flush), 1);
    chk("A_rv1", 32'(redirect_valid), 0);
    tick(); @(negedge clk); chk("A_fl2", 32'(flush), 1);
    tick(); @(negedge clk); chk("A_fl3", 32'(flush), 0);

    // p0 NE false, p1 AL to odd dest
    tick(); push(0, 16'h0050, 3'd3, 4'd1, 1'b0);
    push(1, 16'h0031, 3'd1, 4'd2, 1'b0);
    tick(); idle();
    tick(); Z = 1;
    @(negedge clk);
    chk("B_rv", 32'(redirect_valid), 1);
    chk("B_pc", 32'(redirect_pc), 32'h030);
    chk("B_inv", 32'(redirect_ir0_inv), 1);
    repeat (3) tick();
    idle();

    // p0 LT wins over p1 AL; upper dest bits ignored
    tick(); push(0, 16'hA1F6, 3'd4, 4'd1, 1'b1);
    push(1, 16'h0055, 3'd1, 4'd2, 1'b0);
    tick(); idle();
    tick(); N = 1; V = 0;
    @(negedge clk);
    chk("C_rv", 32'(redirect_valid), 1);
    chk("C_pc", 32'(redirect_pc), 32'h1F6);
    chk("C_inv", 32'(redirect_ir0_inv), 0);
    for (int k = 0; k < 5; k++) begin
      tick(); idle();
      @(negedge clk); chk("C_p1_ignored", 32'(redirect_valid), 0);
    end

    // stall holds the resolve slot
    tick(); push(0, 16'h0042, 3'd1, 4'd0, 1'b0);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      tick(); fetch_next_in = 0;
      @(negedge clk); chk("D_stall_rv", 32'(redirect_valid), 0);
    end
    tick(); fetch_next_in = 1;
    @(negedge clk);
    chk("D_rv", 32'(redirect_valid), 1);
    chk("D_pc", 32'(redirect_pc), 32'h042);

    // push during FLUSH1 is dropped
    tick(); idle(); push(0, 16'h0077, 3'd1, 4'd0, 1'b0);
    tick(); idle();
    @(negedge clk); chk("E_fl", 32'(flush), 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk); chk("E_no_rv", 32'(redirect_valid), 0);
    end

    // reset in FLUSH1 returns to RUN
    tick(); push(0, 16'h0010, 3'd1, 4'd0, 1'b0);
    tick(); idle();
    tick();
    @(negedge clk); chk("R_rv", 32'(redirect_valid), 1);
    tick(); rst = 1;
    tick(); rst = 0;
    @(negedge clk);
    chk("R_flush", 32'(flush), 0);

`ifdef BRANCH_PRED_EN
    // two true EQ resolves at index 5 with t=0
    tick(); rst = 1;
    tick(); rst = 0; idle();
    repeat (2) begin
      push(0, 16'h0010, 3'd2, 4'd5, 1'b0);
      tick(); idle();
      tick(); Z = 1;
      tick(); Z = 0;
      tick(); tick();
    end
    pred_idx = 5;
    @(negedge clk); chk("F_pred", 32'(prediction), 1);
    tick(); rst = 1;
    tick(); rst = 0;
    @(negedge clk); chk("F_pred_rst", 32'(prediction), 0);
`else
    tick(); pred_idx = 5;
    @(negedge clk); chk("F_pred_off", 32'(prediction), 0);
`endif

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      tick();
      rst           = ($urandom_range(0, 99) == 0);
      fetch_next_in = ($urandom_range(0, 9) < 8);
      N = 1'($urandom); V = 1'($urandom); Z = 1'($urandom);
      p0_push = ($urandom_range(0, 2) == 0);
      p1_push = ($urandom_range(0, 3) == 0);
      p0_dest = 16'($urandom); p1_dest = 16'($urandom);
      p0_cond = 3'($urandom); p1_cond = 3'($urandom);
      p0_pidx = 4'($urandom_range(0, 3));
      p1_pidx = 4'($urandom_range(0, 3));
      p0_took = 1'($urandom); p1_took = 1'($urandom);
      pred_idx = 4'($urandom_range(0, 3));
    end
    tick(); rst = 0; idle();
    repeat (4) tick();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
